// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct constants, field positions,
// default bubble PC, RUN/HOLD state encoding and the instruction decoder.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [31:0] BUBBLE_PC_DEF = 32'h0;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] imm_ext;
    } ctrl_t;

    // Control bits, destination and extended immediate for one instruction word.
    function automatic ctrl_t decode_insn(input logic [31:0] insn);
        ctrl_t      c;
        logic [5:0] opc;
        logic [15:0] imm;
        opc = insn[OPC_HI:OPC_LO];
        imm = insn[IMM_HI:IMM_LO];
        c = '0;
        c.imm_ext = {{16{imm[15]}}, imm};
        case (opc)
            OP_RTYPE: begin
                c.dest = insn[RD_HI:RD_LO];
                if (insn[FN_HI:FN_LO] == FN_JR) c.is_jump = 1'b1;
                else                            c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
                c.dest      = insn[RT_HI:RT_LO];
            end
            OP_SW:         c.mem_write = 1'b1;
            OP_BEQ, OP_BNE: c.is_branch = 1'b1;
            OP_J:          c.is_jump   = 1'b1;
            OP_JAL: begin
                c.is_jump   = 1'b1;
                c.reg_write = 1'b1;
                c.dest      = 5'd31;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI: begin
                c.reg_write = 1'b1;
                c.dest      = insn[RT_HI:RT_LO];
            end
            OP_ANDI, OP_ORI: begin
                c.reg_write = 1'b1;
                c.dest      = insn[RT_HI:RT_LO];
                c.imm_ext   = {16'h0, imm};
            end
            default: ;
        endcase
        // r0 is hardwired; writing it is meaningless
        if (c.dest == 5'd0) c.reg_write = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two async read ports, one synchronous write port.
// r0 reads zero and ignores writes. Define DECODE_WB_BYPASS_EN to forward
// a same-cycle write-back to the read ports.
module regfile
    import decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] mem [32];

    // Clear everything on reset, otherwise take the write-back (never r0)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    // Async reads, optionally forwarding the write-back in flight
    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? 32'h0 : mem[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? 32'h0 : mem[raddr_b];
`ifdef DECODE_WB_BYPASS_EN
        if (we && waddr != 5'd0 && waddr == raddr_a) rdata_a = wdata;
        if (we && waddr != 5'd0 && waddr == raddr_b) rdata_b = wdata;
`endif
    end

endmodule

// File: rtl/decode.sv
// Decode stage: field extraction, control generation, register read and
// load-use hazard stall (RUN/HOLD). Outputs registered, 1-cycle latency.
// Optional macro DECODE_WB_BYPASS_EN enables same-cycle write-back forwarding.
module decode
    import decode_pkg::*;
#(
    parameter logic [31:0] BUBBLE_PC = BUBBLE_PC_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic [31:0] insn_in,
    input  logic        do_branch,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic        is_jump
);

    state_t      state;
    logic [31:0] hold_pc, hold_insn;
    logic [31:0] sel_pc, sel_insn;
    logic [31:0] rd_a, rd_b;
    logic        hazard, kill;
    ctrl_t       ctrl;

    // In HOLD the parked instruction is decoded instead of the fetch input
    assign sel_pc   = (state == HOLD) ? hold_pc   : pc_in;
    assign sel_insn = (state == HOLD) ? hold_insn : insn_in;
    assign ctrl     = decode_insn(sel_insn);

    regfile u_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (sel_insn[RS_HI:RS_LO]),
        .raddr_b (sel_insn[RT_HI:RT_LO]),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // Load-use: the load now in execute writes a register this fetch reads
    always_comb begin
        hazard = mem_read && dest_reg != 5'd0 && pc_in != 32'h0 &&
                 (dest_reg == insn_in[RS_HI:RS_LO] || dest_reg == insn_in[RT_HI:RT_LO]);
        stall  = reset_n && !do_branch && state == RUN && hazard;
        kill   = !reset_n || do_branch || stall || sel_pc == 32'h0;
    end

    // State, hold register and registered decode outputs
    always_ff @(posedge clock) begin
        if (!reset_n || do_branch) begin
            state     <= RUN;
            hold_pc   <= '0;
            hold_insn <= '0;
        end else if (stall) begin
            state     <= HOLD;
            hold_pc   <= pc_in;
            hold_insn <= insn_in;
        end else begin
            state     <= RUN;
        end

        if (kill) begin
            pc_out    <= BUBBLE_PC;
            insn_out  <= '0;
            rs_data   <= '0;
            rt_data   <= '0;
            imm_ext   <= '0;
            dest_reg  <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            is_branch <= 1'b0;
            is_jump   <= 1'b0;
        end else begin
            pc_out    <= sel_pc;
            insn_out  <= sel_insn;
            rs_data   <= rd_a;
            rt_data   <= rd_b;
            imm_ext   <= ctrl.imm_ext;
            dest_reg  <= ctrl.dest;
            reg_write <= ctrl.reg_write;
            mem_read  <= ctrl.mem_read;
            mem_write <= ctrl.mem_write;
            is_branch <= ctrl.is_branch;
            is_jump   <= ctrl.is_jump;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for decode with hand-computed expectations.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in, insn_in;
    logic        do_branch, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] pc_out, insn_out, rs_data, rt_data, imm_ext;
    logic [4:0]  dest_reg;
    logic        reg_write, mem_read, mem_write, is_branch, is_jump;

    int checks = 0;
    int errors = 0;

    decode dut (
        .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .insn_in(insn_in),
        .do_branch(do_branch), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .pc_out(pc_out), .insn_out(insn_out), .rs_data(rs_data),
        .rt_data(rt_data), .imm_ext(imm_ext), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jump(is_jump)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] LW_R2   = 32'h8C220000; // lw r2,0(r1)
    localparam logic [31:0] ADD_R3  = 32'h00441820; // add r3,r2,r4
    localparam logic [31:0] ADDI_M1 = 32'h2005FFFF; // addi r5,r0,-1
    localparam logic [31:0] ORI_FF  = 32'h3406FFFF; // ori r6,r0,0xFFFF
    localparam logic [31:0] ADD_R7  = 32'h00E04020; // add r8,r7,r0
    localparam logic [31:0] ADDI_R0 = 32'h20000001; // addi r0,r0,1
    localparam logic [31:0] JR_31   = 32'h03E00008; // jr r31
    localparam logic [31:0] BAD_OP  = 32'hFC000000; // opcode 0x3F

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] insn);
        pc_in   = pc;
        insn_in = insn;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        reset_n = 1'b0; do_branch = 1'b0;
        fetch(32'h0, 32'h0); wb(1'b0, 5'd0, 32'h0);
        tick(); tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_insn", insn_out, 32'h0);
        chk("rst_ctl", {reg_write, mem_read, mem_write, is_branch, is_jump}, 32'h0);
        chk("rst_stall", stall, 1'b0);
        reset_n = 1'b1;

        // seed r1, r4, r7 while fetch is bubbling
        wb(1'b1, 5'd1, 32'h100);      tick();
        wb(1'b1, 5'd4, 32'h4);        tick();
        wb(1'b1, 5'd7, 32'h11111111); tick();
        wb(1'b0, 5'd0, 32'h0);

        fetch(32'h100, ADDI_M1); tick();
        chk("addi_pc", pc_out, 32'h100);
        chk("addi_imm", imm_ext, 32'hFFFFFFFF);
        chk("addi_rw", reg_write, 1'b1);
        chk("addi_dest", dest_reg, 5'd5);

        fetch(32'h104, ORI_FF); tick();
        chk("ori_imm", imm_ext, 32'h0000FFFF);
        chk("ori_dest", dest_reg, 5'd6);

        // load-use: lw r2 then add r3,r2,r4
        fetch(32'h108, LW_R2); #1;
        chk("lw_nostall", stall, 1'b0);
        tick();
        chk("lw_mr", mem_read, 1'b1);
        chk("lw_dest", dest_reg, 5'd2);
        chk("lw_rs", rs_data, 32'h100);
        fetch(32'h10C, ADD_R3); #1;
        chk("hz_stall", stall, 1'b1);
        tick();
        chk("hz_bub_pc", pc_out, 32'h0);
        chk("hz_bub_rw", reg_write, 1'b0);
        chk("hold_stall", stall, 1'b0);
        fetch(32'h110, ADDI_M1); tick();  // ignored while HOLD
        chk("held_pc", pc_out, 32'h10C);
        chk("held_insn", insn_out, ADD_R3);
        chk("held_dest", dest_reg, 5'd3);
        chk("held_rt", rt_data, 32'h4);

        // branch while HOLD drops the parked instruction
        fetch(32'h200, LW_R2); tick();
        fetch(32'h204, ADD_R3); tick();
        do_branch = 1'b1; #1;
        chk("br_stall", stall, 1'b0);
        tick();
        do_branch = 1'b0;
        chk("br_pc", pc_out, 32'h0);
        chk("br_insn", insn_out, 32'h0);
        fetch(32'h300, ADDI_M1); tick();
        chk("br_next_pc", pc_out, 32'h300);

        // write-back racing a read of r7
        wb(1'b1, 5'd7, 32'hDEADBEEF);
        fetch(32'h400, ADD_R7); tick();
`ifdef DECODE_WB_BYPASS_EN
        chk("byp_rs", rs_data, 32'hDEADBEEF);
`else
        chk("byp_rs", rs_data, 32'h11111111);
`endif
        wb(1'b0, 5'd0, 32'h0);
        fetch(32'h404, ADD_R7); tick();
        chk("wb_landed", rs_data, 32'hDEADBEEF);

        // r0 stays zero; dest r0 never writes
        wb(1'b1, 5'd0, 32'h55); fetch(32'h0, 32'h0); tick();
        wb(1'b0, 5'd0, 32'h0);
        fetch(32'h500, ADDI_R0); tick();
        chk("r0_rs", rs_data, 32'h0);
        chk("r0_rw", reg_write, 1'b0);

        // other opcodes and bubble
        fetch(32'h504, JR_31); tick();
        chk("jr_ctl", {reg_write, is_jump}, 2'b01);
        fetch(32'h508, BAD_OP); tick();
        chk("bad_ctl", {reg_write, mem_read, mem_write, is_branch, is_jump}, 5'b0);
        chk("bad_insn", insn_out, BAD_OP);
        fetch(32'h0, ADDI_M1); tick();
        chk("bub_insn", insn_out, 32'h0);
        chk("bub_imm", imm_ext, 32'h0);

        // reset in HOLD
        fetch(32'h600, LW_R2); tick();
        fetch(32'h604, ADD_R3); tick();
        reset_n = 1'b0; tick();
        chk("rst_hold_pc", pc_out, 32'h0);
        chk("rst_hold_mr", mem_read, 1'b0);
        reset_n = 1'b1;
        fetch(32'h700, ADDI_M1); #1;
        chk("rst_run_stall", stall, 1'b0);
        tick();
        chk("rst_run_pc", pc_out, 32'h700);
        fetch(32'h704, ADD_R7); tick();
        chk("rst_rf_clr", rs_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
